// File: rtl/prng_pkg.sv
// Shared types and widths for the xoshiro128++ range sampler.
package prng_pkg;

    localparam int unsigned RND_W   = 32;
    localparam int unsigned TRIES_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        WAIT   = 2'd2
    } state_t;

endpackage

// File: rtl/prng_mask_gen.sv
// Combinational bound -> mask: (bound-1) with every bit below its MSB set.
// bound=0 wraps to all ones, bound=1 gives zero.
module prng_mask_gen
    import prng_pkg::*;
(
    input  logic [RND_W-1:0] bound,
    output logic [RND_W-1:0] mask
);

    logic [RND_W-1:0] smear;

    // Decrement, then right-OR smear so all bits below the leading one are set.
    always_comb begin
        smear = bound - RND_W'(1);
        smear = smear | (smear >> 1);
        smear = smear | (smear >> 2);
        smear = smear | (smear >> 4);
        smear = smear | (smear >> 8);
        smear = smear | (smear >> 16);
        mask  = smear;
    end

endmodule

// File: rtl/prng_range_sampler.sv
// Mask-and-reject sampler: turns raw PRNG words into unbiased integers in [0, bound).
// Drives the PRNG advance strobe itself, once per consumed word.
module prng_range_sampler
    import prng_pkg::*;
#(
    parameter int unsigned MAX_TRIES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [RND_W-1:0]    rnd,
    output logic                rnd_next,
    input  logic                start,
    input  logic [RND_W-1:0]    bound,
    output logic                busy,
    output logic [RND_W-1:0]    result,
    output logic                result_valid,
    output logic                fail,
    output logic [TRIES_W-1:0]  tries
);

    localparam logic [TRIES_W-1:0] MAX_T = TRIES_W'(MAX_TRIES);

    state_t              state, state_next;
    logic [RND_W-1:0]    bound_q, mask_q, mask_d, cand;
    logic [TRIES_W-1:0]  tries_inc;
    logic                accept, give_up;
    logic                load, done_ok, done_fail;

    prng_mask_gen u_mask_gen (
        .bound (bound),
        .mask  (mask_d)
    );

    assign cand      = rnd & mask_q;
    assign tries_inc = tries + TRIES_W'(1);
    assign accept    = (bound_q == '0) || (cand < bound_q);
    assign give_up   = (tries_inc == MAX_T);
    assign busy      = (state != IDLE);

    // State register; reset aborts any request immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode plus the advance strobe and datapath load/complete controls.
    always_comb begin
        state_next = state;
        rnd_next   = 1'b0;
        load       = 1'b0;
        done_ok    = 1'b0;
        done_fail  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                rnd_next = 1'b1;
                if (accept) begin
                    done_ok    = 1'b1;
                    state_next = IDLE;
                end else if (give_up) begin
                    done_fail  = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                state_next = SAMPLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Latched request parameters, try counter and held result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bound_q      <= '0;
            mask_q       <= '0;
            tries        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            fail         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (load) begin
                bound_q <= bound;
                mask_q  <= mask_d;
                tries   <= '0;
                fail    <= 1'b0;
            end
            if (rnd_next) begin
                tries <= tries_inc;
            end
            if (done_ok) begin
                result       <= cand;
                result_valid <= 1'b1;
            end
            if (done_fail) begin
                result       <= '0;
                fail         <= 1'b1;
                result_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prng_range_sampler.sv
// Directed bench for prng_range_sampler with a scripted word source.
module tb_prng_range_sampler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] bound = '0;
    logic [31:0] rnd;
    logic        rnd_next;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;
    logic        fail;
    logic [7:0]  tries;

    int total = 0;
    int bad = 0;

    logic [31:0] seq [0:63];
    int unsigned consumed = 0;
    int unsigned base = 0;
    int unsigned consec = 0;
    logic        prev_next = 1'b0;

    prng_range_sampler #(.MAX_TRIES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rnd          (rnd),
        .rnd_next     (rnd_next),
        .start        (start),
        .bound        (bound),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .fail         (fail),
        .tries        (tries)
    );

    always #5 clk = ~clk;

    // Word source: presents seq[] from the current base, advancing on each strobe.
    assign rnd = seq[6'(consumed - base)];

    always @(posedge clk) begin
        if (rnd_next) begin
            consumed <= consumed + 1;
            if (prev_next) consec <= consec + 1;
        end
        prev_next <= rnd_next;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                        input logic [31:0] rest);
        for (int i = 0; i < 64; i++) seq[i] = rest;
        seq[0] = w0;
        seq[1] = w1;
        seq[2] = w2;
        base = consumed;
    endtask

    // Issue one request and return the cycle count until result_valid (bounded).
    task automatic run_req(input logic [31:0] b, output int cyc);
        bound = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!result_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    int cyc;
    int unsigned mark;
    int rv_seen;

    initial begin
        fill(32'h0, 32'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 32'd0);
        chk("reset_rnd_next", rnd_next, 32'd0);
        chk("reset_valid", result_valid, 32'd0);
        chk("reset_fail", fail, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_tries", tries, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: bound=6, mask 7; 7 rejected, 0xD&7=5 accepted
        fill(32'h7, 32'hD, 32'h0, 32'h0);
        run_req(32'd6, cyc);
        chk("t1_latency", cyc, 32'd4);
        chk("t1_result", result, 32'd5);
        chk("t1_tries", tries, 32'd2);
        chk("t1_fail", fail, 32'd0);
        chk("t1_pulses", consumed - base, 32'd2);
        @(posedge clk); #1;
        chk("t1_valid_pulse", result_valid, 32'd0);
        chk("t1_result_held", result, 32'd5);

        // 2: bound=1 -> always 0
        fill(32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
        run_req(32'd1, cyc);
        chk("t2_latency", cyc, 32'd2);
        chk("t2_result", result, 32'd0);
        chk("t2_tries", tries, 32'd1);
        chk("t2_pulses", consumed - base, 32'd1);

        // 3: bound=0 -> full range
        fill(32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
        run_req(32'd0, cyc);
        chk("t3_result", result, 32'hFFFF_FFFF);
        chk("t3_tries", tries, 32'd1);
        chk("t3_fail", fail, 32'd0);

        // 4: bound=5 with rnd always 7 -> exhaust
        fill(32'h7, 32'h7, 32'h7, 32'h7);
        run_req(32'd5, cyc);
        chk("t4_latency", cyc, 32'd32);
        chk("t4_fail", fail, 32'd1);
        chk("t4_result", result, 32'd0);
        chk("t4_tries", tries, 32'd16);
        chk("t4_pulses", consumed - base, 32'd16);
        @(posedge clk); #1;
        chk("t4_fail_held", fail, 32'd1);
        chk("t4_idle", busy, 32'd0);

        // 5: start while busy ignored; back-to-back start on result_valid
        fill(32'h7, 32'hD, 32'h9, 32'h0);
        bound = 32'd6;
        start = 1'b1;
        @(posedge clk); #1;
        chk("t5_busy", busy, 32'd1);
        bound = 32'd3;
        @(posedge clk); #1;
        chk("t5_wait_next", rnd_next, 32'd0);
        start = 1'b0;
        @(posedge clk); #1;
        chk("t5_sample_next", rnd_next, 32'd1);
        @(posedge clk); #1;
        chk("t5_valid", result_valid, 32'd1);
        chk("t5_result", result, 32'd5);
        chk("t5_tries", tries, 32'd2);
        bound = 32'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t5_b2b_busy", busy, 32'd1);
        chk("t5_b2b_tries", tries, 32'd0);
        @(posedge clk); #1;
        chk("t5_b2b_valid", result_valid, 32'd1);
        chk("t5_b2b_result", result, 32'd0);
        chk("t5_b2b_tries1", tries, 32'd1);
        chk("t5_pulses", consumed - base, 32'd3);

        // 6: reset asserted while in WAIT
        fill(32'h7, 32'h7, 32'h7, 32'h7);
        bound = 32'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("t6_in_wait", busy, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 32'd0);
        chk("t6_rst_next", rnd_next, 32'd0);
        chk("t6_rst_tries", tries, 32'd0);
        chk("t6_rst_fail", fail, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mark = consumed;
        rv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (result_valid) rv_seen++;
        end
        chk("t6_no_valid", rv_seen, 32'd0);
        chk("t6_no_pulses", consumed - mark, 32'd0);

        chk("no_consecutive_next", consec, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
